// File: rtl/uart_cmd_link.sv
// -----------------------------------------------------------------------------
// uart_cmd_link
//
// Byte-oriented debug command link between a UART and a processor core.
// Commands arrive one byte at a time from the UART RX buffer:
//   'S' (8'h53) : single-step the processor (one-cycle step pulse)
//   'C' (8'h43) : continue, run_en goes high
//   'H' (8'h48) : halt, run_en goes low
//   'R' (8'h52) : read; the next received byte is the address, and
//                 N_BYTES of rd_data are returned least-significant first
//   other       : ERR_BYTE is returned
//
// Ports
//   clock      : system clock, rising edge
//   reset      : synchronous active-low reset
//   rx_ready   : UART RX holds an unread byte
//   rx_buf_out : UART RX byte
//   rd_uart    : one-cycle pulse that clears the UART RX flag
//   tx_busy    : UART TX buffer occupied
//   t_data     : byte offered to UART TX
//   tx_done    : one-cycle pulse that loads t_data into UART TX
//   step       : one-cycle single-step request
//   run_en     : processor free-run enable (level)
//   rd_addr    : debug read address
//   rd_data    : debug read data, valid one cycle after rd_addr changes
// -----------------------------------------------------------------------------
module uart_cmd_link #(
    parameter int         N_BYTES  = 4,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_ready,
    input  logic [7:0]           rx_buf_out,
    output logic                 rd_uart,
    input  logic                 tx_busy,
    output logic [7:0]           t_data,
    output logic                 tx_done,
    output logic                 step,
    output logic                 run_en,
    output logic [7:0]           rd_addr,
    input  logic [8*N_BYTES-1:0] rd_data
);

    localparam int         W     = 8 * N_BYTES;
    localparam logic [3:0] N_CNT = 4'(N_BYTES);

    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_CONT = 8'h43;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] CMD_READ = 8'h52;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CMD_ACK   = 3'd1,
        ADDR_WAIT = 3'd2,
        ADDR_ACK  = 3'd3,
        FETCH     = 3'd4,
        TX_PUT    = 3'd5,
        TX_GAP    = 3'd6,
        TX_WAIT   = 3'd7
    } state_t;

    state_t         state_r;
    logic [7:0]     cmd_r;
    logic [W-1:0]   shift_r;
    logic [3:0]     count_r;

    // Command FSM; all outputs are registered and the pulse outputs default low
    // every cycle so each pulse lasts exactly one cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
            cmd_r   <= 8'h00;
            shift_r <= '0;
            count_r <= 4'd0;
            rd_uart <= 1'b0;
            tx_done <= 1'b0;
            step    <= 1'b0;
            run_en  <= 1'b0;
            rd_addr <= 8'h00;
            t_data  <= 8'h00;
        end else begin
            rd_uart <= 1'b0;
            tx_done <= 1'b0;
            step    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rx_ready) begin
                        cmd_r   <= rx_buf_out;
                        rd_uart <= 1'b1;
                        state_r <= CMD_ACK;
                    end
                end
                CMD_ACK: begin
                    case (cmd_r)
                        CMD_STEP: begin
                            step    <= 1'b1;
                            state_r <= IDLE;
                        end
                        CMD_CONT: begin
                            run_en  <= 1'b1;
                            state_r <= IDLE;
                        end
                        CMD_HALT: begin
                            run_en  <= 1'b0;
                            state_r <= IDLE;
                        end
                        CMD_READ: begin
                            state_r <= ADDR_WAIT;
                        end
                        default: begin
                            shift_r <= W'(ERR_BYTE);
                            count_r <= 4'd1;
                            state_r <= TX_PUT;
                        end
                    endcase
                end
                ADDR_WAIT: begin
                    // Any byte here is an address, even one that looks like a command.
                    if (rx_ready) begin
                        rd_addr <= rx_buf_out;
                        rd_uart <= 1'b1;
                        state_r <= ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    // rd_addr changed on entry here, so rd_data is valid by FETCH.
                    state_r <= FETCH;
                end
                FETCH: begin
                    shift_r <= rd_data;
                    count_r <= N_CNT;
                    state_r <= TX_PUT;
                end
                TX_PUT: begin
                    if (!tx_busy) begin
                        t_data  <= shift_r[7:0];
                        tx_done <= 1'b1;
                        state_r <= TX_GAP;
                    end
                end
                TX_GAP: begin
                    // Dead cycle: the UART raises tx_busy the cycle after tx_done.
                    state_r <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (!tx_busy) begin
                        count_r <= count_r - 4'd1;
                        shift_r <= shift_r >> 4'd8;
                        if (count_r == 4'd1) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= TX_PUT;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_link.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_link
//
// Self-checking bench for uart_cmd_link. Behavioural UART RX/TX models drive
// the DUT; a byte-stream reference model predicts the response bytes, step
// pulses and run_en level from the sequence of bytes the DUT consumes.
// -----------------------------------------------------------------------------
module tb_uart_cmd_link;

    logic        clock;
    logic        reset;
    logic        rx_ready;
    logic [7:0]  rx_buf_out;
    logic        rd_uart;
    logic        tx_busy;
    logic [7:0]  t_data;
    logic        tx_done;
    logic        step;
    logic        run_en;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;

    uart_cmd_link #(
        .N_BYTES  (4),
        .ERR_BYTE (8'hEE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_ready   (rx_ready),
        .rx_buf_out (rx_buf_out),
        .rd_uart    (rd_uart),
        .tx_busy    (tx_busy),
        .t_data     (t_data),
        .tx_done    (tx_done),
        .step       (step),
        .run_en     (run_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // UART models and observation state
    logic [7:0] rx_q[$];
    int         rx_gap = 0;
    int         busy_cnt = 0;
    bit         hold_busy = 1'b0;
    bit         prev_rd = 1'b0;
    bit         prev_tx = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    int         step_cnt = 0;
    int         tx_cnt = 0;
    int         rd_cnt = 0;
    logic [7:0] tx_log[$];

    // Reference model (byte-stream level)
    logic [7:0] exp_tx[$];
    int         mdl_steps = 0;
    bit         mdl_run = 1'b0;
    bit         mdl_addr_next = 1'b0;

    function automatic logic [31:0] data_of(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEADBEEF;
        return {a ^ 8'h5C, 8'(a + 8'd1), ~a, 8'(a * 8'd3)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_rx(input logic [7:0] b);
        logic [31:0] d;
        if (mdl_addr_next) begin
            mdl_addr_next = 1'b0;
            d = data_of(b);
            for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
        end else begin
            case (b)
                8'h53:   mdl_steps++;
                8'h43:   mdl_run = 1'b1;
                8'h48:   mdl_run = 1'b0;
                8'h52:   mdl_addr_next = 1'b1;
                default: exp_tx.push_back(8'hEE);
            endcase
        end
    endtask

    // One clock cycle: observe DUT outputs of the cycle just started (input
    // variables still hold what the DUT sampled), then set the inputs for it.
    task automatic tick();
        @(posedge clock);
        #1;
        check("pulse_overlap", {31'd0, rd_uart & tx_done}, 32'd0);
        check("pulse_repeat", {31'd0, (rd_uart & prev_rd) | (tx_done & prev_tx)}, 32'd0);
        if (rd_uart) begin
            rd_cnt++;
            check("rd_uart_ready", {31'd0, rx_ready}, 32'd1);
            model_rx(rx_buf_out);
        end
        if (tx_done) begin
            tx_cnt++;
            tx_log.push_back(t_data);
            check("tx_done_busy", {31'd0, tx_busy}, 32'd0);
            if (exp_tx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_extra: got byte %0h, expected no tx_done", t_data);
            end else begin
                check("tx_byte", {24'd0, t_data}, {24'd0, exp_tx.pop_front()});
            end
        end
        if (step) step_cnt++;
        // RX model
        if (prev_rd) rx_ready = 1'b0;
        if (!rx_ready) begin
            if (rx_gap > 0) begin
                rx_gap--;
            end else if (rx_q.size() > 0) begin
                rx_buf_out = rx_q.pop_front();
                rx_ready   = 1'b1;
                rx_gap     = $urandom_range(0, 3);
            end
        end
        // TX model
        if (prev_tx) begin
            tx_busy  = 1'b1;
            busy_cnt = $urandom_range(1, 6);
        end else if (tx_busy && !hold_busy) begin
            if (busy_cnt > 0) busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
        if (hold_busy) tx_busy = 1'b1;
        // Read data valid one cycle after the address changes
        rd_data   = data_of(prev_addr);
        prev_rd   = rd_uart;
        prev_tx   = tx_done;
        prev_addr = rd_addr;
    endtask

    task automatic drain(input string name);
        int budget = 20000;
        while ((rx_q.size() > 0 || rx_ready || exp_tx.size() > 0 || tx_busy || mdl_addr_next)
               && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got pending tx %0d, expected 0", name, exp_tx.size());
        end
        repeat (6) tick();
    endtask

    task automatic wait_tx(input int target, input string name);
        int budget = 5000;
        while (tx_cnt < target && budget > 0) begin
            tick();
            budget--;
        end
        check({name, "_wait_tx"}, tx_cnt, target);
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        bit         two;
        int         exp_steps;
        bit         exp_run;
        int         exp_ntx;
        logic [7:0] exp_first;
        logic [7:0] exp_last;
        logic [7:0] exp_addr;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int s0, t0, r0;
        vecs[0]  = '{8'h53, 8'h00, 1'b0, 1, 1'b0, 0, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{8'h43, 8'h00, 1'b0, 0, 1'b1, 0, 8'h00, 8'h00, 8'h00};
        vecs[2]  = '{8'h43, 8'h00, 1'b0, 0, 1'b1, 0, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{8'h48, 8'h00, 1'b0, 0, 1'b0, 0, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{8'h48, 8'h00, 1'b0, 0, 1'b0, 0, 8'h00, 8'h00, 8'h00};
        vecs[5]  = '{8'h7A, 8'h00, 1'b0, 0, 1'b0, 1, 8'hEE, 8'hEE, 8'h00};
        vecs[6]  = '{8'h43, 8'h00, 1'b0, 0, 1'b1, 0, 8'h00, 8'h00, 8'h00};
        vecs[7]  = '{8'h00, 8'h00, 1'b0, 0, 1'b1, 1, 8'hEE, 8'hEE, 8'h00};
        vecs[8]  = '{8'h53, 8'h00, 1'b0, 1, 1'b1, 0, 8'h00, 8'h00, 8'h00};
        vecs[9]  = '{8'h52, 8'h10, 1'b1, 0, 1'b1, 4, 8'hEF, 8'hDE, 8'h10};
        vecs[10] = '{8'h52, 8'h53, 1'b1, 0, 1'b1, 4, 8'hF9, 8'h0F, 8'h53};
        vecs[11] = '{8'h48, 8'h00, 1'b0, 0, 1'b0, 0, 8'h00, 8'h00, 8'h00};
        vecs[12] = '{8'hFF, 8'h00, 1'b0, 0, 1'b0, 1, 8'hEE, 8'hEE, 8'h00};

        reset      = 1'b0;
        rx_ready   = 1'b0;
        rx_buf_out = 8'h00;
        tx_busy    = 1'b0;
        rd_data    = 32'h0;
        repeat (3) tick();
        check("reset_rd_uart", {31'd0, rd_uart}, 32'd0);
        check("reset_tx_done", {31'd0, tx_done}, 32'd0);
        check("reset_step", {31'd0, step}, 32'd0);
        check("reset_run_en", {31'd0, run_en}, 32'd0);
        check("reset_rd_addr", {24'd0, rd_addr}, 32'd0);
        check("reset_t_data", {24'd0, t_data}, 32'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Table-driven single commands
        for (int v = 0; v < 13; v++) begin
            s0 = step_cnt;
            t0 = tx_cnt;
            r0 = rd_cnt;
            rx_q.push_back(vecs[v].b0);
            if (vecs[v].two) rx_q.push_back(vecs[v].b1);
            drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d_steps", v), step_cnt - s0, vecs[v].exp_steps);
            check($sformatf("vec%0d_run_en", v), {31'd0, run_en}, {31'd0, vecs[v].exp_run});
            check($sformatf("vec%0d_ntx", v), tx_cnt - t0, vecs[v].exp_ntx);
            check($sformatf("vec%0d_nrd", v), rd_cnt - r0, vecs[v].two ? 2 : 1);
            if (vecs[v].exp_ntx > 0 && tx_cnt - t0 == vecs[v].exp_ntx) begin
                check($sformatf("vec%0d_first", v), {24'd0, tx_log[t0]}, {24'd0, vecs[v].exp_first});
                check($sformatf("vec%0d_last", v), {24'd0, tx_log[tx_cnt-1]}, {24'd0, vecs[v].exp_last});
            end
            if (vecs[v].two) check($sformatf("vec%0d_rd_addr", v), {24'd0, rd_addr}, {24'd0, vecs[v].exp_addr});
        end

        // Busy held for 200 cycles in the middle of a read frame
        t0 = tx_cnt;
        rx_q.push_back(8'h52);
        rx_q.push_back(8'h10);
        wait_tx(t0 + 1, "hold");
        hold_busy = 1'b1;
        repeat (200) tick();
        check("hold_no_tx", tx_cnt - t0, 1);
        hold_busy = 1'b0;
        drain("hold");
        check("hold_ntx", tx_cnt - t0, 4);
        if (tx_cnt - t0 == 4)
            check("hold_frame", {tx_log[t0+3], tx_log[t0+2], tx_log[t0+1], tx_log[t0]}, 32'hDEADBEEF);

        // Reset after the second response byte aborts the frame
        rx_q.push_back(8'h43);
        drain("pre_abort");
        check("abort_run_before", {31'd0, run_en}, 32'd1);
        t0 = tx_cnt;
        rx_q.push_back(8'h52);
        rx_q.push_back(8'h22);
        wait_tx(t0 + 2, "abort");
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_tx.delete();
        mdl_run = 1'b0;
        mdl_addr_next = 1'b0;
        check("abort_run_en", {31'd0, run_en}, 32'd0);
        check("abort_rd_addr", {24'd0, rd_addr}, 32'd0);
        check("abort_t_data", {24'd0, t_data}, 32'd0);
        repeat (100) tick();
        check("abort_no_more_tx", tx_cnt - t0, 2);
        s0 = step_cnt;
        rx_q.push_back(8'h53);
        drain("after_abort");
        check("after_abort_step", step_cnt - s0, 1);
        check("after_abort_run", {31'd0, run_en}, 32'd0);

        // Randomized command stream against the reference model
        for (int i = 0; i < 200; i++) begin
            logic [7:0] b;
            case ($urandom_range(0, 4))
                0: rx_q.push_back(8'h53);
                1: rx_q.push_back(8'h43);
                2: rx_q.push_back(8'h48);
                3: begin
                    rx_q.push_back(8'h52);
                    b = 8'($urandom);
                    rx_q.push_back(b);
                end
                default: begin
                    b = 8'($urandom);
                    if (b == 8'h53 || b == 8'h43 || b == 8'h48 || b == 8'h52) b = 8'h00;
                    rx_q.push_back(b);
                end
            endcase
        end
        drain("random");
        check("random_steps", step_cnt, mdl_steps);
        check("random_run_en", {31'd0, run_en}, {31'd0, mdl_run});
        check("random_pending", exp_tx.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
